simon_data_in_block: RTL and testbench

SIMON_DATA_IN_BLOCK -- requirements
Module: simon_data_in

---
 rtl/simon_data_in_block.sv | 124 ++++++++++++
 tb/tb_simon_data_in_block.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_data_in_block.sv
// SIMON packet input block: splits incoming packets into data blocks and keys.
// Optional sequence check of the count byte: define SIMON_DATAIN_SEQCHK_EN.
module simon_data_in_block #(
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic                        clk,
    input  logic                        nR,
    input  logic                        newPKT,
    input  logic                        loadDATA,
    input  logic                        loadKEY,
    input  logic [8*(2+N/2)-1:0]        in,
    output logic                        loadPKT,
    output logic                        donePKT,
    output logic                        newKEY,
    output logic                        newDATA,
    output logic [7:0]                  infoIN,
    output logic [7:0]                  countIN,
    output logic [1:0][N-1:0]           inDATA,
    output logic [M-1:0][N-1:0]         KEY
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_WAIT_D = 3'd2;
    localparam logic [2:0] S_WAIT_K = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;

    logic [2:0]     r_state;
    logic [4*N-1:0] r_payload;
    logic           w_seq_ok;
    logic           w_is_data;
    logic           w_is_key;

`ifdef SIMON_DATAIN_SEQCHK_EN
    logic [7:0] r_exp_cnt;

    assign w_seq_ok = (countIN == r_exp_cnt);

    // Expected packet count, advanced by every packet accepted in LOAD
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_exp_cnt <= 8'd0;
        end else if (r_state == S_LOAD && (w_is_data || w_is_key)) begin
            r_exp_cnt <= r_exp_cnt + 8'd1;
        end
    end
`else
    assign w_seq_ok = 1'b1;
`endif

    assign w_is_data = w_seq_ok && (infoIN[1:0] == 2'b01);
    assign w_is_key  = w_seq_ok && (infoIN[1:0] == 2'b10);

    // Packet FSM with registered pulse and payload outputs
    always_ff @(posedge clk or negedge nR) begin
        if (!nR) begin
            r_state   <= S_IDLE;
            r_payload <= '0;
            loadPKT   <= 1'b0;
            donePKT   <= 1'b0;
            newKEY    <= 1'b0;
            newDATA   <= 1'b0;
            infoIN    <= 8'd0;
            countIN   <= 8'd0;
            inDATA    <= '0;
            KEY       <= '0;
        end else begin
            loadPKT <= 1'b0;
            donePKT <= 1'b0;
            newKEY  <= 1'b0;
            newDATA <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (newPKT) begin
                        infoIN    <= in[7:0];
                        countIN   <= in[15:8];
                        r_payload <= in[8*(2+N/2)-1:16];
                        loadPKT   <= 1'b1;
                        r_state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_is_data) begin
                        r_state <= S_WAIT_D;
                    end else if (w_is_key) begin
                        r_state <= S_WAIT_K;
                    end else begin
                        donePKT <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end
                S_WAIT_D: begin
                    if (loadDATA) begin
                        inDATA[0] <= r_payload[N-1:0];
                        inDATA[1] <= r_payload[2*N-1:N];
                        newDATA   <= 1'b1;
                        donePKT   <= 1'b1;
                        r_state   <= S_HOLD;
                    end
                end
                S_WAIT_K: begin
                    if (loadKEY) begin
                        for (int i = 0; i < M; i++) begin
                            KEY[i] <= r_payload[i*N +: N];
                        end
                        newKEY  <= 1'b1;
                        donePKT <= 1'b1;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!newPKT) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simon_data_in_block.sv
// Directed testbench for simon_data_in_block (N=32, M=4).
// Pulse counters sample outputs on the falling edge.
module tb_simon_data_in_block;

  localparam int N = 32;
  localparam int M = 4;

  logic                 clk = 1'b0;
  logic                 nR;
  logic                 newPKT;
  logic                 loadDATA;
  logic                 loadKEY;
  logic [8*(2+N/2)-1:0] in;
  logic                 loadPKT;
  logic                 donePKT;
  logic                 newKEY;
  logic                 newDATA;
  logic [7:0]           infoIN;
  logic [7:0]           countIN;
  logic [1:0][N-1:0]    inDATA;
  logic [M-1:0][N-1:0]  KEY;

  int errors = 0;
  int checks = 0;
  int n_load = 0;
  int n_done = 0;
  int n_data = 0;
  int n_key  = 0;
  int s_load, s_done, s_data, s_key;

  simon_data_in_block #(.N(N), .M(M)) dut (
    .clk      (clk),
    .nR       (nR),
    .newPKT   (newPKT),
    .loadDATA (loadDATA),
    .loadKEY  (loadKEY),
    .in       (in),
    .loadPKT  (loadPKT),
    .donePKT  (donePKT),
    .newKEY   (newKEY),
    .newDATA  (newDATA),
    .infoIN   (infoIN),
    .countIN  (countIN),
    .inDATA   (inDATA),
    .KEY      (KEY)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (loadPKT) n_load++;
    if (donePKT) n_done++;
    if (newDATA) n_data++;
    if (newKEY)  n_key++;
  end

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic snap();
    s_load = n_load;
    s_done = n_done;
    s_data = n_data;
    s_key  = n_key;
  endtask

  function automatic logic [8*(2+N/2)-1:0] mk(
    input logic [4*N-1:0] pl,
    input logic [7:0]     cnt,
    input logic [7:0]     info
  );
    return {pl, cnt, info};
  endfunction

  initial begin
    nR = 1'b0; newPKT = 1'b0; loadDATA = 1'b0;
    loadKEY = 1'b0; in = '0;
    tick();
    tick();
    chk("rst_loadPKT", loadPKT, 1'b0);
    chk("rst_donePKT", donePKT, 1'b0);
    chk("rst_newDATA", newDATA, 1'b0);
    chk("rst_newKEY", newKEY, 1'b0);
    chk("rst_infoIN", infoIN, 8'h00);
    chk("rst_countIN", countIN, 8'h00);
    chk("rst_inDATA", inDATA, 64'h0);
    chk("rst_KEY", KEY, 128'h0);

    nR = 1'b1;
    snap();
    newPKT = 1'b1;
    in = mk(128'h0, 8'h00, 8'h00);
    tick();
    chk("disc_loadPKT", loadPKT, 1'b1);
    tick();
    newPKT = 1'b0;
    chk("disc_loadPKT_off", loadPKT, 1'b0);
    chk("disc_donePKT", donePKT, 1'b1);
    tick();
    chk("disc_donePKT_off", donePKT, 1'b0);
    tick();
    chk("disc_n_load", n_load - s_load, 1);
    chk("disc_n_done", n_done - s_done, 1);
    chk("disc_n_data", n_data - s_data, 0);
    chk("disc_n_key", n_key - s_key, 0);

    snap();
    newPKT = 1'b1;
    loadDATA = 1'b1;
    in = mk(128'h0123456789ABCDEF, 8'h00, 8'h01);
    tick();
    newPKT = 1'b0;
    in = '0;
    chk("dat_loadPKT", loadPKT, 1'b1);
    chk("dat_infoIN", infoIN, 8'h01);
    tick();
    chk("dat_newDATA_e2", newDATA, 1'b0);
    tick();
    chk("dat_newDATA_e3", newDATA, 1'b1);
    chk("dat_donePKT_e3", donePKT, 1'b1);
    chk("dat_inDATA1", inDATA[1], 32'h01234567);
    chk("dat_inDATA0", inDATA[0], 32'h89ABCDEF);
    tick();
    loadDATA = 1'b0;
    chk("dat_newDATA_off", newDATA, 1'b0);
    chk("dat_n_data", n_data - s_data, 1);
    chk("dat_n_done", n_done - s_done, 1);

    snap();
    newPKT = 1'b1;
    loadDATA = 1'b1;
    in = mk(128'h1B1A1918_13121110_0B0A0908_03020100,
            8'h01, 8'h02);
    tick();
    newPKT = 1'b0;
    tick();
    newPKT = 1'b1;
    in = mk(128'hFFFF, 8'h77, 8'h01);
    tick();
    newPKT = 1'b0;
    chk("key_ign_infoIN", infoIN, 8'h02);
    chk("key_ign_countIN", countIN, 8'h01);
    for (int i = 0; i < 4; i++) tick();
    chk("key_wait_n_key", n_key - s_key, 0);
    chk("key_wait_n_data", n_data - s_data, 0);
    chk("key_wait_n_done", n_done - s_done, 0);
    loadKEY = 1'b1;
    tick();
    loadKEY = 1'b0;
    loadDATA = 1'b0;
    chk("key_newKEY", newKEY, 1'b1);
    chk("key_donePKT", donePKT, 1'b1);
    chk("key_KEY3", KEY[3], 32'h1B1A1918);
    chk("key_KEY2", KEY[2], 32'h13121110);
    chk("key_KEY1", KEY[1], 32'h0B0A0908);
    chk("key_KEY0", KEY[0], 32'h03020100);
    chk("key_inDATA_kept", inDATA,
        64'h01234567_89ABCDEF);
    tick();
    chk("key_newKEY_off", newKEY, 1'b0);
    chk("key_n_key", n_key - s_key, 1);
    chk("key_n_done", n_done - s_done, 1);

    snap();
    newPKT = 1'b1;
    in = mk(128'h0, 8'h02, 8'h03);
    for (int i = 0; i < 10; i++) tick();
    newPKT = 1'b0;
    tick();
    tick();
    chk("held_n_load", n_load - s_load, 1);
    chk("held_n_done", n_done - s_done, 1);
    chk("held_n_data", n_data - s_data, 0);

    snap();
    newPKT = 1'b1;
    in = mk(128'h5555, 8'h02, 8'h01);
    tick();
    newPKT = 1'b0;
    tick();
    nR = 1'b0;
    #1;
    chk("wrst_infoIN", infoIN, 8'h00);
    chk("wrst_inDATA", inDATA, 64'h0);
    chk("wrst_KEY", KEY, 128'h0);
    chk("wrst_loadPKT", loadPKT, 1'b0);
    tick();
    nR = 1'b1;
    loadDATA = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("wrst_n_data", n_data - s_data, 0);
    chk("wrst_n_done", n_done - s_done, 0);

    newPKT = 1'b1;
    in = mk(128'hDEADBEEF_CAFEF00D, 8'h00, 8'h01);
    tick();
    newPKT = 1'b0;
    chk("post_loadPKT", loadPKT, 1'b1);
    tick();
    tick();
    chk("post_newDATA", newDATA, 1'b1);
    chk("post_inDATA", inDATA,
        64'hDEADBEEF_CAFEF00D);
    tick();
    loadDATA = 1'b0;

`ifdef SIMON_DATAIN_SEQCHK_EN
    nR = 1'b0;
    tick();
    nR = 1'b1;
    loadDATA = 1'b1;
    snap();
    newPKT = 1'b1;
    in = mk(128'h1, 8'h00, 8'h01);
    tick();
    newPKT = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    newPKT = 1'b1;
    in = mk(128'h2, 8'h01, 8'h01);
    tick();
    newPKT = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("seq_two_data", n_data - s_data, 2);
    chk("seq_inDATA", inDATA[0], 32'h2);
    snap();
    newPKT = 1'b1;
    in = mk(128'h3, 8'h03, 8'h01);
    tick();
    newPKT = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("seq_bad_data", n_data - s_data, 0);
    chk("seq_bad_done", n_done - s_done, 1);
    chk("seq_bad_kept", inDATA[0], 32'h2);
    loadDATA = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
